fetch_stage: RTL

//  Instruction-fetch stage directly upstream of the combinational instruction memory.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core constants and the IF/ID pipeline bundle.
// Decode and later stages import the same widths and encodings.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [ADDR_W-1:0]  PC_STEP    = 16'd2;
    localparam logic [ADDR_W-1:0]  RESET_PC   = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hEFFF;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus2;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble control.
// A bubble carries NOP_INSTR and zeroed addresses.
module if_id_reg
    import cpu_pkg::INSTR_W;
    import cpu_pkg::if_id_t;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t empty;

    always_comb begin
        empty          = '0;
        empty.instr    = NOP_INSTR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= empty;
        end else if (bubble) begin
            q <= empty;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and HALT detection
// in front of a combinational instruction memory.
module fetch_stage
    import cpu_pkg::INSTR_W;
    import cpu_pkg::ADDR_W;
    import cpu_pkg::PC_STEP;
    import cpu_pkg::if_id_t;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
    parameter logic [INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus2,
    output logic               halted
);

    // Instructions are halfword aligned, so bit 0 of pc is forced low.
    localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic              halted_next;
    logic              load;
    logic              bubble;
    if_id_t            cap;
    if_id_t            q;

    assign pc_inc    = pc + PC_STEP;
    assign imem_addr = pc;

    always_comb begin
        pc_next     = pc;
        halted_next = halted;
        load        = 1'b0;
        bubble      = 1'b0;
        if (redirect_valid) begin
            pc_next     = redirect_pc & ALIGN;
            bubble      = 1'b1;
            halted_next = 1'b0;
        end else if (halted) begin
            bubble = 1'b1;
        end else if (stall && !flush) begin
            pc_next = pc;
        end else if (stall) begin
            bubble = 1'b1;
        end else if (flush) begin
            pc_next = pc_inc;
            bubble  = 1'b1;
        end else begin
            pc_next = pc_inc;
            load    = 1'b1;
            if (imem_instr == HALT_INSTR) begin
                halted_next = 1'b1;
            end
        end
    end

    always_comb begin
        cap          = '0;
        cap.valid    = 1'b1;
        cap.instr    = imem_instr;
        cap.pc       = pc;
        cap.pc_plus2 = pc_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC & ALIGN;
            halted <= 1'b0;
        end else begin
            pc     <= pc_next;
            halted <= halted_next;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .bubble (bubble),
        .d      (cap),
        .q      (q)
    );

    assign if_id_valid    = q.valid;
    assign if_id_instr    = q.instr;
    assign if_id_pc       = q.pc;
    assign if_id_pc_plus2 = q.pc_plus2;

endmodule
